// File: rtl/microondas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : microondas_pkg
// Purpose  : Shared state encoding, digit limits and quick-start preset for
//            the microwave oven controller.
// Revision : 1.0
// ============================================================================
package microondas_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_COOK  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] DSEG_MAX   = 4'd5;

    localparam logic [3:0] QUICK_MIN  = 4'd0;
    localparam logic [3:0] QUICK_DSEG = 4'd3;
    localparam logic [3:0] QUICK_SEG  = 4'd0;

    // Tens-of-seconds digit cannot exceed 5 on a m:ss display.
    function automatic logic [3:0] clamp_dseg(input logic [3:0] d);
        return (d > DSEG_MAX) ? DSEG_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : digit_shift_reg
// Purpose  : Three-digit keypad buffer (min, dseg, seg) with shift-in, zero,
//            preset and clamped tens-of-seconds output.
// Revision : 1.0
// ============================================================================
module digit_shift_reg
    import microondas_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [3:0] digit,
    input  logic       zero_en,
    input  logic       preset_en,
    input  logic [3:0] preset_min,
    input  logic [3:0] preset_dseg,
    input  logic [3:0] preset_seg,
    output logic [3:0] data_min,
    output logic [3:0] data_dseg,
    output logic [3:0] data_seg,
    output logic       is_zero
);

    logic [3:0] r_min;
    logic [3:0] r_dseg;
    logic [3:0] r_seg;

    // Zeroing wins over preset, which wins over a shift in the same cycle.
    always_ff @(posedge clk) begin
        if (clear || zero_en) begin
            r_min  <= 4'd0;
            r_dseg <= 4'd0;
            r_seg  <= 4'd0;
        end else if (preset_en) begin
            r_min  <= preset_min;
            r_dseg <= preset_dseg;
            r_seg  <= preset_seg;
        end else if (shift_en) begin
            r_min  <= r_dseg;
            r_dseg <= r_seg;
            r_seg  <= digit;
        end
    end

    assign data_min  = r_min;
    assign data_dseg = clamp_dseg(r_dseg);
    assign data_seg  = r_seg;
    assign is_zero   = (r_min == 4'd0) && (r_dseg == 4'd0) && (r_seg == 4'd0);

endmodule
`default_nettype wire

// File: rtl/microondas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : microondas_ctrl
// Purpose  : Microwave oven sequencer: keypad entry, counter-chain load,
//            cook/pause control and end-of-cook alarm.
//            Optional feature macro: MICROONDAS_QUICKSTART_EN (start in IDLE
//            presets 0:30 and cooks immediately).
// Revision : 1.0
// ============================================================================
module microondas_ctrl
    import microondas_pkg::*;
#(
    parameter int ALARM_TICKS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       count_zero,
    output logic [3:0] data_min,
    output logic [3:0] data_dseg,
    output logic [3:0] data_seg,
    output logic       cnt_load_n,
    output logic       cnt_en,
    output logic       mag_on,
    output logic       alarm,
    output logic [2:0] state_o
);

    localparam int TICK_W = (ALARM_TICKS < 1) ? 1 : $clog2(ALARM_TICKS + 1);

    state_t            r_state;
    logic              r_cnt_load_n;
    logic              r_mag_on;
    logic              r_alarm;
    logic [TICK_W-1:0] r_tick_cnt;

    logic w_buf_zero;
    logic w_key_ok;
    logic w_go_load;
    logic w_quick;
    logic w_alarm_last;
    logic w_shift;
    logic w_zero;

    assign w_key_ok  = key_valid && (key_digit <= DIGIT_MAX);
    assign w_go_load = start && door_closed && !stop && !w_buf_zero;

`ifdef MICROONDAS_QUICKSTART_EN
    assign w_quick = (r_state == ST_IDLE) && start && door_closed && !stop;
`else
    assign w_quick = 1'b0;
`endif

    assign w_alarm_last = tick_1hz && ((int'(r_tick_cnt) + 1) >= ALARM_TICKS);

    // A key pressed in the same cycle ENTRY is left is dropped, so the value
    // that passed the nonzero check is the one loaded.
    assign w_shift = w_key_ok &&
                     ((r_state == ST_IDLE && !w_quick) ||
                      (r_state == ST_ENTRY && !stop && !w_go_load));

    assign w_zero = ((r_state == ST_ENTRY || r_state == ST_PAUSE) && stop) ||
                    ((r_state == ST_DONE) && (stop || w_alarm_last));

    digit_shift_reg u_digits (
        .clk         (clk),
        .clear       (clear),
        .shift_en    (w_shift),
        .digit       (key_digit),
        .zero_en     (w_zero),
        .preset_en   (w_quick),
        .preset_min  (QUICK_MIN),
        .preset_dseg (QUICK_DSEG),
        .preset_seg  (QUICK_SEG),
        .data_min    (data_min),
        .data_dseg   (data_dseg),
        .data_seg    (data_seg),
        .is_zero     (w_buf_zero)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state      <= ST_IDLE;
            r_cnt_load_n <= 1'b1;
            r_mag_on     <= 1'b0;
            r_alarm      <= 1'b0;
            r_tick_cnt   <= '0;
        end else begin
            r_cnt_load_n <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_quick) begin
                        r_state      <= ST_LOAD;
                        r_cnt_load_n <= 1'b0;
                    end else if (w_key_ok) begin
                        r_state <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_go_load) begin
                        r_state      <= ST_LOAD;
                        r_cnt_load_n <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state  <= ST_COOK;
                    r_mag_on <= 1'b1;
                end
                ST_COOK: begin
                    if (count_zero) begin
                        r_state    <= ST_DONE;
                        r_mag_on   <= 1'b0;
                        r_alarm    <= 1'b1;
                        r_tick_cnt <= '0;
                    end else if (!door_closed || stop) begin
                        r_state  <= ST_PAUSE;
                        r_mag_on <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (start && door_closed) begin
                        r_state  <= ST_COOK;
                        r_mag_on <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (stop || w_alarm_last) begin
                        r_state <= ST_IDLE;
                        r_alarm <= 1'b0;
                    end else if (tick_1hz) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mag_on <= 1'b0;
                    r_alarm  <= 1'b0;
                end
            endcase
        end
    end

    // The decrement must be suppressed in the very cycle a pause is requested.
    assign cnt_en     = (r_state == ST_COOK) && tick_1hz && door_closed && !stop;
    assign cnt_load_n = r_cnt_load_n;
    assign mag_on     = r_mag_on;
    assign alarm      = r_alarm;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_microondas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_microondas_ctrl
// Purpose  : Directed self-checking bench for microondas_ctrl.
// Revision : 1.0
// ============================================================================
module tb_microondas_ctrl;

    logic       clk;
    logic       clear;
    logic       tick_1hz;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       count_zero;
    logic [3:0] data_min;
    logic [3:0] data_dseg;
    logic [3:0] data_seg;
    logic       cnt_load_n;
    logic       cnt_en;
    logic       mag_on;
    logic       alarm;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_COOK  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    microondas_ctrl #(.ALARM_TICKS(3)) dut (
        .clk         (clk),
        .clear       (clear),
        .tick_1hz    (tick_1hz),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .count_zero  (count_zero),
        .data_min    (data_min),
        .data_dseg   (data_dseg),
        .data_seg    (data_seg),
        .cnt_load_n  (cnt_load_n),
        .cnt_en      (cnt_en),
        .mag_on      (mag_on),
        .alarm       (alarm),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    endtask

    task automatic chk_data(input string tag, input logic [3:0] m, input logic [3:0] d,
                            input logic [3:0] s);
        chk({tag, ".min"},  {4'd0, data_min},  {4'd0, m});
        chk({tag, ".dseg"}, {4'd0, data_dseg}, {4'd0, d});
        chk({tag, ".seg"},  {4'd0, data_seg},  {4'd0, s});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    initial begin
        clear = 1'b1; tick_1hz = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        start = 1'b0; stop = 1'b0; door_closed = 1'b1; count_zero = 1'b0;
        step(); step();
        clear = 1'b0;

        // Reset state
        chk("rst.state", {5'd0, state_o}, {5'd0, S_IDLE});
        chk_data("rst.data", 4'd0, 4'd0, 4'd0);
        chk("rst.load_n", {7'd0, cnt_load_n}, 8'd1);
        chk("rst.cnt_en", {7'd0, cnt_en}, 8'd0);
        chk("rst.mag_on", {7'd0, mag_on}, 8'd0);
        chk("rst.alarm",  {7'd0, alarm},  8'd0);

        // Digit entry 1,3,0 then invalid key 12
        key(4'd1);
        chk("key1.state", {5'd0, state_o}, {5'd0, S_ENTRY});
        chk_data("key1", 4'd0, 4'd0, 4'd1);
        key(4'd3);
        key(4'd0);
        chk_data("key130", 4'd1, 4'd3, 4'd0);
        key(4'd12);
        chk_data("key12", 4'd1, 4'd3, 4'd0);
        chk("key12.state", {5'd0, state_o}, {5'd0, S_ENTRY});

        // Start -> one-cycle LOAD -> COOK
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load.state", {5'd0, state_o}, {5'd0, S_LOAD});
        chk("load.load_n", {7'd0, cnt_load_n}, 8'd0);
        chk_data("load", 4'd1, 4'd3, 4'd0);
        step();
        chk("cook.state", {5'd0, state_o}, {5'd0, S_COOK});
        chk("cook.load_n", {7'd0, cnt_load_n}, 8'd1);
        chk("cook.mag_on", {7'd0, mag_on}, 8'd1);
        chk("cook.cnt_en_idle", {7'd0, cnt_en}, 8'd0);
        tick_1hz = 1'b1;
        #1;
        chk("cook.cnt_en_tick", {7'd0, cnt_en}, 8'd1);
        step();
        tick_1hz = 1'b0;
        #1;
        chk("cook.cnt_en_after", {7'd0, cnt_en}, 8'd0);

        // Keys ignored while cooking
        key(4'd5);
        chk_data("cook.key", 4'd1, 4'd3, 4'd0);
        chk("cook.key.state", {5'd0, state_o}, {5'd0, S_COOK});

        // Door opens with a tick in the same cycle -> decrement suppressed
        door_closed = 1'b0;
        tick_1hz = 1'b1;
        #1;
        chk("door.cnt_en_forced", {7'd0, cnt_en}, 8'd0);
        step();
        tick_1hz = 1'b0;
        chk("pause.state", {5'd0, state_o}, {5'd0, S_PAUSE});
        chk("pause.mag_on", {7'd0, mag_on}, 8'd0);
        tick_1hz = 1'b1;
        #1;
        chk("pause.cnt_en", {7'd0, cnt_en}, 8'd0);
        tick_1hz = 1'b0;

        // Start with door still open is blocked
        start = 1'b1;
        step();
        chk("pause.door_open_start", {5'd0, state_o}, {5'd0, S_PAUSE});

        // Door closes, start -> resume COOK without a load pulse
        door_closed = 1'b1;
        step();
        start = 1'b0;
        chk("resume.state", {5'd0, state_o}, {5'd0, S_COOK});
        chk("resume.load_n", {7'd0, cnt_load_n}, 8'd1);
        chk("resume.mag_on", {7'd0, mag_on}, 8'd1);

        // count_zero beats stop -> DONE
        count_zero = 1'b1;
        stop = 1'b1;
        step();
        count_zero = 1'b0;
        stop = 1'b0;
        chk("done.state", {5'd0, state_o}, {5'd0, S_DONE});
        chk("done.alarm", {7'd0, alarm}, 8'd1);
        chk("done.mag_on", {7'd0, mag_on}, 8'd0);

        // Alarm holds for three ticks
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
        chk("done.tick1.alarm", {7'd0, alarm}, 8'd1);
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
        chk("done.tick2.state", {5'd0, state_o}, {5'd0, S_DONE});
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
        chk("done.tick3.state", {5'd0, state_o}, {5'd0, S_IDLE});
        chk("done.tick3.alarm", {7'd0, alarm}, 8'd0);
        chk_data("done.zeroed", 4'd0, 4'd0, 4'd0);

        // Keys 7,9: tens-of-seconds clamped to 5
        key(4'd7);
        key(4'd9);
        chk_data("clamp.entry", 4'd0, 4'd5, 4'd9);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clamp.load_n", {7'd0, cnt_load_n}, 8'd0);
        chk_data("clamp.load", 4'd0, 4'd5, 4'd9);
        step();
        chk("clamp.cook", {5'd0, state_o}, {5'd0, S_COOK});

        // clear mid-COOK
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr.state", {5'd0, state_o}, {5'd0, S_IDLE});
        chk("clr.mag_on", {7'd0, mag_on}, 8'd0);
        chk("clr.load_n", {7'd0, cnt_load_n}, 8'd1);
        chk("clr.alarm", {7'd0, alarm}, 8'd0);
        chk("clr.cnt_en", {7'd0, cnt_en}, 8'd0);
        chk_data("clr", 4'd0, 4'd0, 4'd0);

        // Door open blocks start in ENTRY; stop returns to IDLE with zero buffer
        key(4'd5);
        door_closed = 1'b0;
        start = 1'b1;
        step();
        chk("entry.door_open", {5'd0, state_o}, {5'd0, S_ENTRY});
        stop = 1'b1;
        door_closed = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b0;
        chk("entry.stop", {5'd0, state_o}, {5'd0, S_IDLE});
        chk_data("entry.stop", 4'd0, 4'd0, 4'd0);

        // Stop in COOK -> PAUSE; start+stop in PAUSE -> IDLE
        key(4'd2);
        start = 1'b1; step(); start = 1'b0; step();
        chk("sp.cook", {5'd0, state_o}, {5'd0, S_COOK});
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("sp.pause", {5'd0, state_o}, {5'd0, S_PAUSE});
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("sp.idle", {5'd0, state_o}, {5'd0, S_IDLE});
        chk_data("sp.idle", 4'd0, 4'd0, 4'd0);

        // Start in IDLE
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef MICROONDAS_QUICKSTART_EN
        chk("quick.state", {5'd0, state_o}, {5'd0, S_LOAD});
        chk("quick.load_n", {7'd0, cnt_load_n}, 8'd0);
        chk_data("quick", 4'd0, 4'd3, 4'd0);
`else
        chk("noquick.state", {5'd0, state_o}, {5'd0, S_IDLE});
        chk("noquick.load_n", {7'd0, cnt_load_n}, 8'd1);
        chk_data("noquick", 4'd0, 4'd0, 4'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
